// File: rtl/pe_ctx_sequencer.sv
`timescale 1ns/1ps
// pe_ctx_sequencer
// Per-PE context sequencer for the CGRA array. Stores a small program of ALU
// contexts {last, br, tgt, opcode}, steps through it one context per cycle,
// stalls on loads until memory returns valid data, takes branches on the ALU
// condition flag and repeats the program iter_num times.
//
// Ports:
//   Clk, Reset        clock, asynchronous active-high reset
//   cfg_we_i/addr/data context write port (accepted only while idle)
//   start_i           start program (samples iter_num_i, 0 treated as 1)
//   abort_i           synchronous abort back to idle, no done pulse
//   alu_cond_i        ALU condition flag, used for branch decisions
//   data_req_valid_i  load data valid from memory
//   exec_en_o         global execute enable
//   alu_en_o          ALU enable
//   opcode_o          opcode of the presented context
//   data_req_o        load request
//   busy_o            program running
//   done_o            one-cycle completion pulse
//   pc_o              current context index
module pe_ctx_sequencer #(
  parameter  int NCTX = 16,
  localparam int AW   = $clog2(NCTX),
  localparam int CW   = AW + 7
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          cfg_we_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [CW-1:0] cfg_data_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [7:0]    iter_num_i,
  input  logic          alu_cond_i,
  input  logic          data_req_valid_i,
  output logic          exec_en_o,
  output logic          alu_en_o,
  output logic [4:0]    opcode_o,
  output logic          data_req_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] pc_o
);

  localparam logic [4:0] OP_LOAD = 5'b00111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_LD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    iter_q, iter_d;
  logic [7:0]    iter_num_q, iter_num_d;

  logic [CW-1:0] ctx_mem [NCTX];

  // Decoded fields of the context at the current pc
  logic [CW-1:0] cur;
  logic [4:0]    cur_op;
  logic [AW-1:0] cur_tgt;
  logic          cur_br;
  logic          cur_last;
  logic          cur_load;
  logic          complete;

  assign cur      = ctx_mem[pc_q];
  assign cur_op   = cur[4:0];
  assign cur_tgt  = cur[AW+4:5];
  assign cur_br   = cur[AW+5];
  assign cur_last = cur[AW+6];
  assign cur_load = (cur_op == OP_LOAD);

  assign pc_o = pc_q;

  // Context memory; writes are locked out once a program is running
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NCTX; i++) begin
        ctx_mem[i] <= '0;
      end
    end else if (cfg_we_i && state_q == S_IDLE) begin
      ctx_mem[cfg_addr_i] <= cfg_data_i;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      iter_q     <= '0;
      iter_num_q <= 8'd1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iter_q     <= iter_d;
      iter_num_q <= iter_num_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iter_d     = iter_q;
    iter_num_d = iter_num_q;
    exec_en_o  = 1'b0;
    alu_en_o   = 1'b0;
    opcode_o   = '0;
    data_req_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    complete   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          iter_num_d = (iter_num_i == 8'd0) ? 8'd1 : iter_num_i;
          pc_d       = '0;
          iter_d     = '0;
          state_d    = S_RUN;
        end
      end

      // RUN and WAIT_LD share the output and completion logic: a held load
      // context in WAIT_LD looks exactly like a load presented in RUN.
      S_RUN, S_WAIT_LD: begin
        exec_en_o  = 1'b1;
        alu_en_o   = 1'b1;
        busy_o     = 1'b1;
        opcode_o   = cur_op;
        data_req_o = cur_load;
        complete   = !cur_load || data_req_valid_i;
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (!complete) begin
          state_d = S_WAIT_LD;
        end else if (cur_br && alu_cond_i) begin
          pc_d    = cur_tgt;
          state_d = S_RUN;
        end else if (cur_last && (iter_q < iter_num_q - 8'd1)) begin
          pc_d    = '0;
          iter_d  = iter_q + 8'd1;
          state_d = S_RUN;
        end else if (cur_last) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + AW'(1);
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
`timescale 1ns/1ps
module tb_pe_ctx_sequencer;
  localparam int NCTX = 16;
  localparam int AW   = 4;
  localparam int CW   = AW + 7;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          cfg_we_i;
  logic [AW-1:0] cfg_addr_i;
  logic [CW-1:0] cfg_data_i;
  logic          start_i;
  logic          abort_i;
  logic [7:0]    iter_num_i;
  logic          alu_cond_i;
  logic          data_req_valid_i;
  logic          exec_en_o;
  logic          alu_en_o;
  logic [4:0]    opcode_o;
  logic          data_req_o;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] pc_o;

  pe_ctx_sequencer #(.NCTX(NCTX)) dut (
    .Clk(Clk), .Reset(Reset),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .start_i(start_i), .abort_i(abort_i), .iter_num_i(iter_num_i),
    .alu_cond_i(alu_cond_i), .data_req_valid_i(data_req_valid_i),
    .exec_en_o(exec_en_o), .alu_en_o(alu_en_o), .opcode_o(opcode_o),
    .data_req_o(data_req_o), .busy_o(busy_o), .done_o(done_o), .pc_o(pc_o)
  );

  always #5 Clk = ~Clk;

  // {exec_en, alu_en, data_req, busy, done, opcode, pc}
  logic [13:0] obs;
  assign obs = {exec_en_o, alu_en_o, data_req_o, busy_o, done_o, opcode_o, pc_o};

  typedef struct packed {
    logic [4:0]    op;
    logic [AW-1:0] pc;
    logic          req;
  } exp_t;

  exp_t sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  function automatic logic [CW-1:0] mk(input logic last, input logic br,
                                       input logic [AW-1:0] tgt, input logic [4:0] op);
    return {last, br, tgt, op};
  endfunction

  function automatic logic [13:0] run_vec(input exp_t e);
    return {1'b1, 1'b1, e.req, 1'b1, 1'b0, e.op, e.pc};
  endfunction

  // All drivers below are called at a falling edge and return at one.
  task automatic wr(input logic [AW-1:0] a, input logic [CW-1:0] d);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    @(negedge Clk);
    cfg_we_i = 1'b0;
  endtask

  task automatic start(input logic [7:0] n);
    iter_num_i = n; start_i = 1'b1;
    @(negedge Clk);
    start_i = 1'b0;
  endtask

  task automatic push(input logic [4:0] op, input logic [AW-1:0] pc, input logic req);
    exp_t e;
    e.op = op; e.pc = pc; e.req = req;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    cfg_we_i = 0; cfg_addr_i = '0; cfg_data_i = '0; start_i = 0; abort_i = 0;
    iter_num_i = 8'd1; alu_cond_i = 0; data_req_valid_i = 0;
    repeat (2) @(negedge Clk);
    total++;
    if (obs !== 14'd0) $display("FAIL reset_hold got=%h required=0", obs); else passed++;
    Reset = 1'b0;
    @(negedge Clk);
    total++;
    if (obs !== 14'd0) $display("FAIL reset_release got=%h required=0", obs); else passed++;
  endtask

  task automatic test_straight();
    bit fin = 0;
    exp_t e;
    wr(0, mk(0, 0, 0, 5'b00001));
    wr(1, mk(0, 0, 0, 5'b00011));
    wr(2, mk(1, 0, 0, 5'b00101));
    push(5'b00001, 0, 0); push(5'b00011, 1, 0); push(5'b00101, 2, 0);
    start(8'd1);
    for (int k = 0; k < 10 && !fin; k++) begin
      if (done_o) fin = 1;
      else if (busy_o) begin
        total++;
        if (sb.size() == 0) $display("FAIL straight_extra got=%h required=none", obs);
        else begin
          e = sb.pop_front();
          if (obs !== run_vec(e)) $display("FAIL straight_ctx got=%h required=%h", obs, run_vec(e));
          else passed++;
        end
      end
      if (!fin) @(negedge Clk);
    end
    total++;
    if (!fin || sb.size() != 0) $display("FAIL straight_done got done=%0d left=%0d required done=1 left=0", fin, sb.size());
    else passed++;
    sb.delete();
    @(negedge Clk);
    total++;
    if (obs[13:5] !== 9'd0) $display("FAIL straight_idle got=%h required=0", obs[13:5]); else passed++;
  endtask

  task automatic test_load_stall();
    bit fin = 0;
    int unsigned req_cycles = 0;
    exp_t e;
    wr(0, mk(1, 0, 0, 5'b00111));
    repeat (4) push(5'b00111, 0, 1);
    data_req_valid_i = 0;
    start(8'd1);
    for (int k = 0; k < 12 && !fin; k++) begin
      if (done_o) fin = 1;
      else if (busy_o) begin
        total++;
        if (data_req_o) req_cycles++;
        if (sb.size() == 0) $display("FAIL load_extra got=%h required=none", obs);
        else begin
          e = sb.pop_front();
          if (obs !== run_vec(e)) $display("FAIL load_ctx got=%h required=%h", obs, run_vec(e));
          else passed++;
        end
      end
      data_req_valid_i = (k == 3);
      if (!fin) @(negedge Clk);
    end
    data_req_valid_i = 0;
    total++;
    if (!fin || sb.size() != 0 || req_cycles != 4)
      $display("FAIL load_done got done=%0d req_cycles=%0d required done=1 req_cycles=4", fin, req_cycles);
    else passed++;
    sb.delete();
    @(negedge Clk);
  endtask

  task automatic test_branch(input logic cond);
    bit fin = 0;
    exp_t e;
    wr(0, mk(0, 1, 2, 5'b10000));
    wr(1, mk(0, 0, 0, 5'b00001));
    wr(2, mk(1, 0, 0, 5'b01100));
    push(5'b10000, 0, 0);
    if (!cond) push(5'b00001, 1, 0);
    push(5'b01100, 2, 0);
    start(8'd1);
    for (int k = 0; k < 10 && !fin; k++) begin
      if (done_o) fin = 1;
      else if (busy_o) begin
        total++;
        if (sb.size() == 0) $display("FAIL branch%0d_extra got=%h required=none", cond, obs);
        else begin
          e = sb.pop_front();
          if (obs !== run_vec(e)) $display("FAIL branch%0d_ctx got=%h required=%h", cond, obs, run_vec(e));
          else passed++;
        end
      end
      alu_cond_i = (k == 0) ? cond : 1'b0;
      if (!fin) @(negedge Clk);
    end
    alu_cond_i = 0;
    total++;
    if (!fin || sb.size() != 0) $display("FAIL branch%0d_done got done=%0d left=%0d required done=1 left=0", cond, fin, sb.size());
    else passed++;
    sb.delete();
    @(negedge Clk);
  endtask

  task automatic test_iterations(input logic [7:0] n, input int unsigned reps);
    bit fin = 0;
    int unsigned busy_cycles = 0;
    exp_t e;
    for (int i = 0; i < NCTX; i++) wr(AW'(i), mk(i == NCTX - 1, 0, 0, 5'b11000));
    for (int r = 0; r < int'(reps); r++)
      for (int i = 0; i < NCTX; i++) push(5'b11000, AW'(i), 0);
    start(n);
    for (int k = 0; k < 70 && !fin; k++) begin
      if (done_o) fin = 1;
      else if (busy_o) begin
        busy_cycles++;
        total++;
        if (sb.size() == 0) $display("FAIL iter%0d_extra got=%h required=none", n, obs);
        else begin
          e = sb.pop_front();
          if (obs !== run_vec(e)) $display("FAIL iter%0d_ctx got=%h required=%h", n, obs, run_vec(e));
          else passed++;
        end
      end
      if (!fin) @(negedge Clk);
    end
    total++;
    if (!fin || busy_cycles != reps * NCTX)
      $display("FAIL iter%0d_done got done=%0d busy=%0d required done=1 busy=%0d", n, fin, busy_cycles, reps * NCTX);
    else passed++;
    sb.delete();
    @(negedge Clk);
  endtask

  // Relies on the 16-nop program left by test_iterations.
  task automatic test_abort_lockout();
    bit stop = 0;
    bit fin = 0;
    exp_t e;
    for (int i = 0; i <= 5; i++) push(5'b11000, AW'(i), 0);
    start(8'd1);
    for (int k = 0; k < 10 && !stop; k++) begin
      total++;
      if (sb.size() == 0) $display("FAIL abort_extra got=%h required=none", obs);
      else begin
        e = sb.pop_front();
        if (obs !== run_vec(e)) $display("FAIL abort_ctx got=%h required=%h", obs, run_vec(e));
        else passed++;
      end
      cfg_we_i = (k == 2); cfg_addr_i = 3; cfg_data_i = mk(1, 0, 0, 5'b00001);
      if (pc_o == 5) begin abort_i = 1'b1; stop = 1; end
      @(negedge Clk);
    end
    abort_i = 0; cfg_we_i = 0;
    total++;
    if (obs[13:5] !== 9'd0) $display("FAIL abort_idle got=%h required=0", obs[13:5]); else passed++;
    @(negedge Clk);
    total++;
    if (done_o !== 1'b0) $display("FAIL abort_nodone got=%b required=0", done_o); else passed++;
    sb.delete();
    for (int i = 0; i < NCTX; i++) push(5'b11000, AW'(i), 0);
    start(8'd1);
    for (int k = 0; k < 25 && !fin; k++) begin
      if (done_o) fin = 1;
      else if (busy_o) begin
        total++;
        if (sb.size() == 0) $display("FAIL lockout_extra got=%h required=none", obs);
        else begin
          e = sb.pop_front();
          if (obs !== run_vec(e)) $display("FAIL lockout_ctx got=%h required=%h", obs, run_vec(e));
          else passed++;
        end
      end
      if (!fin) @(negedge Clk);
    end
    total++;
    if (!fin || sb.size() != 0) $display("FAIL lockout_done got done=%0d left=%0d required done=1 left=0", fin, sb.size());
    else passed++;
    sb.delete();
    @(negedge Clk);
  endtask

  task automatic test_write_with_start();
    bit fin = 0;
    exp_t e;
    push(5'b00010, 0, 0);
    cfg_we_i = 1; cfg_addr_i = 0; cfg_data_i = mk(1, 0, 0, 5'b00010);
    start(8'd1);
    cfg_we_i = 0;
    for (int k = 0; k < 6 && !fin; k++) begin
      if (done_o) fin = 1;
      else if (busy_o) begin
        total++;
        if (sb.size() == 0) $display("FAIL wrstart_extra got=%h required=none", obs);
        else begin
          e = sb.pop_front();
          if (obs !== run_vec(e)) $display("FAIL wrstart_ctx got=%h required=%h", obs, run_vec(e));
          else passed++;
        end
      end
      if (!fin) @(negedge Clk);
    end
    total++;
    if (!fin || sb.size() != 0) $display("FAIL wrstart_done got done=%0d left=%0d required done=1 left=0", fin, sb.size());
    else passed++;
    sb.delete();
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_load();
    exp_t e;
    wr(0, mk(1, 0, 0, 5'b00111));
    data_req_valid_i = 0;
    start(8'd1);
    @(negedge Clk);
    push(5'b00111, 0, 1);
    e = sb.pop_front();
    total++;
    if (obs !== run_vec(e)) $display("FAIL rstld_wait got=%h required=%h", obs, run_vec(e)); else passed++;
    #2 Reset = 1'b1;
    #1;
    total++;
    if (obs !== 14'd0) $display("FAIL rstld_async got=%h required=0", obs); else passed++;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    total++;
    if (obs !== 14'd0) $display("FAIL rstld_release got=%h required=0", obs); else passed++;
    push(5'b00000, 0, 0); push(5'b00000, 1, 0);
    start(8'd1);
    for (int k = 0; k < 2; k++) begin
      total++;
      e = sb.pop_front();
      if (obs !== run_vec(e)) $display("FAIL rstld_cleared got=%h required=%h", obs, run_vec(e));
      else passed++;
      abort_i = (k == 1);
      @(negedge Clk);
    end
    abort_i = 0;
    total++;
    if (obs[13:5] !== 9'd0) $display("FAIL rstld_abort got=%h required=0", obs[13:5]); else passed++;
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_straight();
    test_load_stall();
    test_branch(1'b1);
    test_branch(1'b0);
    test_iterations(8'd3, 3);
    test_iterations(8'd0, 1);
    test_abort_lockout();
    test_write_with_start();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
